oric_key_matrix: RTL

Parametrised PS/2-to-matrix keyboard block for the Oric core. It keeps a full key-state array with one bit per matrix position, so any number of simultaneous keys appear in the selected column without per-key special cases. It also adds a FIFO-fed key injector (auto-type / paste) that presses and releases matrix positions on a fixed timer. It sits between the PS/2 front end and the VIA/PSG keyboard scan path and drives the active-low row sense lines for the column the CPU selects.

---
 rtl/oric_key_matrix.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/oric_key_matrix.sv
// PS/2-to-matrix keyboard for the Oric core: full key-state array, FIFO-fed key
// injector for auto-type, and registered active-low row sense for the scanned column.
module oric_key_matrix #(
    parameter int NCOLS       = 8,
    parameter int NROWS       = 8,
    parameter int HOLD_CYCLES = 480000,
    parameter int FIFO_DEPTH  = 16,
    parameter int SHIFT_COL   = 4,
    parameter int SHIFT_ROW   = 4,
    localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1,
    localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1,
    localparam int DW = 1 + CW + RW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [10:0]      ps2_key,
    input  logic [CW-1:0]    col,
    output logic [NROWS-1:0] row_n,
    input  logic             inj_valid,
    input  logic [DW-1:0]    inj_data,
    output logic             inj_ready,
    output logic             inj_busy,
    output logic             swnmi,
    output logic             swrst,
    output logic             any_key
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Returns {hit, col[3:0], row[3:0]}; arrows match with or without the E0 prefix.
    function automatic logic [8:0] key_map(input logic ext, input logic [7:0] code);
        logic [8:0] m;
        case ({ext, code})
            9'h05a:         m = {1'b1, 4'd7, 4'd5};
            9'h01c:         m = {1'b1, 4'd6, 4'd5};
            9'h029:         m = {1'b1, 4'd4, 4'd0};
            9'h012:         m = {1'b1, 4'd4, 4'd4};
            9'h059:         m = {1'b1, 4'd7, 4'd4};
            9'h014:         m = {1'b1, 4'd2, 4'd4};
            9'h045:         m = {1'b1, 4'd7, 4'd2};
            9'h011:         m = {1'b1, 4'd5, 4'd4};
            9'h066, 9'h171: m = {1'b1, 4'd5, 4'd5};
            9'h075, 9'h175: m = {1'b1, 4'd4, 4'd3};
            9'h06b, 9'h16b: m = {1'b1, 4'd4, 4'd5};
            9'h072, 9'h172: m = {1'b1, 4'd4, 4'd6};
            9'h074, 9'h174: m = {1'b1, 4'd4, 4'd7};
            default:        m = 9'd0;
        endcase
        return m;
    endfunction

    logic                        r_tog;
    logic [NCOLS-1:0][NROWS-1:0] r_key_state;
    logic [DW-1:0]               r_mem [FIFO_DEPTH];
    logic [AW:0]                 r_wr_ptr;
    logic [AW:0]                 r_rd_ptr;
    logic [1:0]                  r_state;
    logic [TW-1:0]               r_timer;
    logic                        r_inj_shift;
    logic [CW-1:0]               r_inj_col;
    logic [RW-1:0]               r_inj_row;

    logic                        w_event;
    logic [8:0]                  w_map;
    logic                        w_map_ok;
    logic [CW-1:0]               w_map_col;
    logic [RW-1:0]               w_map_row;
    logic                        w_empty;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push;
    logic [NCOLS-1:0][NROWS-1:0] w_inj;
    logic [NCOLS-1:0][NROWS-1:0] w_eff;
    logic [NROWS-1:0]            w_sel;

    assign w_event   = ps2_key[10] != r_tog;
    assign w_map     = key_map(ps2_key[8], ps2_key[7:0]);
    assign w_map_ok  = w_map[8] && ({28'd0, w_map[7:4]} < NCOLS) && ({28'd0, w_map[3:0]} < NROWS);
    assign w_map_col = CW'(w_map[7:4]);
    assign w_map_row = RW'(w_map[3:0]);

    assign w_empty   = r_wr_ptr == r_rd_ptr;
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_push    = inj_valid && (!w_full || w_pop);
    assign inj_ready = !w_full;
    assign inj_busy  = !w_empty || (r_state != ST_IDLE);

    // Injected matrix bits while the injector is holding a key.
    always_comb begin
        w_inj = '0;
        if (r_state == ST_PRESS) begin
            w_inj[r_inj_col][r_inj_row] = 1'b1;
            if (r_inj_shift) begin
                w_inj[SHIFT_COL][SHIFT_ROW] = 1'b1;
            end else begin
                w_inj[SHIFT_COL][SHIFT_ROW] = w_inj[SHIFT_COL][SHIFT_ROW];
            end
        end else begin
            w_inj = '0;
        end
    end

    assign w_eff = r_key_state | w_inj;

    // Column select of the effective matrix; out-of-range columns read as idle.
    always_comb begin
        w_sel = '0;
        if ({{(32-CW){1'b0}}, col} < NCOLS) begin
            w_sel = w_eff[col];
        end else begin
            w_sel = '0;
        end
    end

    // PS/2 event tracking, physical key state and F10/F11 break/reset keys.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tog       <= ps2_key[10];
            r_key_state <= '0;
            swnmi       <= 1'b0;
            swrst       <= 1'b0;
        end else begin
            r_tog <= ps2_key[10];
            if (w_event) begin
                case ({ps2_key[8], ps2_key[7:0]})
                    9'h009:  swnmi <= ps2_key[9];
                    9'h078:  swrst <= ps2_key[9];
                    default: begin
                        if (w_map_ok) begin
                            r_key_state[w_map_col][w_map_row] <= ps2_key[9];
                        end else begin
                            r_key_state <= r_key_state;
                        end
                    end
                endcase
            end else begin
                r_key_state <= r_key_state;
            end
        end
    end

    // Injection FIFO storage; contents need no reset since pointers gate them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= inj_data;
        end else begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
        end
    end

    // FIFO pointers and the press/release injector sequencer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_inj_shift <= 1'b0;
            r_inj_col   <= '0;
            r_inj_row   <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + (AW+1)'(1) : r_wr_ptr;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        {r_inj_shift, r_inj_col, r_inj_row} <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                        r_timer  <= HOLD_LAST;
                        r_state  <= ST_PRESS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRESS, ST_RELEASE: begin
                    if (r_timer == '0) begin
                        r_timer <= HOLD_LAST;
                        r_state <= (r_state == ST_PRESS) ? ST_RELEASE : ST_IDLE;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered row sense and any-key flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_n   <= '1;
            any_key <= 1'b0;
        end else begin
            row_n   <= ~w_sel;
            any_key <= |w_eff;
        end
    end

endmodule
